// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO pointer/flag controller and its pointer sub-block.
// Reset is synchronous; RESET_ACTIVE gives the level on the reset pin that clears state.
package fifo_pkg;
    localparam int   MEM_SIZE     = 8;
    localparam int   WORD_SIZE    = 10;
    localparam int   PTR          = 3;
    localparam int   CNT_W        = PTR + 1;
    localparam logic RESET_ACTIVE = 1'b0;
endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around PTR-bit address pointer; advances by one on i_inc, wraps by natural overflow.
// Registered output, one-cycle update latency, no backpressure (caller gates i_inc).
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int PTR = fifo_pkg::PTR
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_inc,
    output logic [PTR-1:0] o_ptr
);
    logic [PTR-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_reset == RESET_ACTIVE) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + PTR'(1);
        end
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy/flag controller feeding the memory block; strobes are combinational, state one edge later.
// Requests at full/empty are dropped and reported on o_error (sticky until reset when FIFO_ERR_STICKY_EN is defined).
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int MEM_SIZE  = fifo_pkg::MEM_SIZE,
    parameter int WORD_SIZE = fifo_pkg::WORD_SIZE,
    parameter int PTR       = fifo_pkg::PTR
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_push_req,
    input  logic           i_pop_req,
    input  logic [PTR:0]   i_thr_high,
    input  logic [PTR:0]   i_thr_low,
    output logic           o_push,
    output logic           o_pop,
    output logic [PTR-1:0] o_wr_ptr,
    output logic [PTR-1:0] o_rd_ptr,
    output logic [PTR:0]   o_fifo_count,
    output logic           o_full,
    output logic           o_empty,
    output logic           o_almost_full,
    output logic           o_almost_empty,
    output logic           o_data_valid,
    output logic           o_error
);
    localparam int CW = PTR + 1;

    // Depth must be a power of two so pointer overflow is the wrap; the word width must be meaningful.
    if ((MEM_SIZE != (1 << PTR)) || (WORD_SIZE < 1)) begin : g_param_err
        $error("fifo_ctrl: MEM_SIZE must equal 2**PTR and WORD_SIZE must be positive");
    end

    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_almost_full;
    logic          r_almost_empty;
    logic          r_data_valid;
    logic          r_error;

    logic          w_push;
    logic          w_pop;
    logic          w_err_now;
    logic [CW-1:0] w_cnt_nxt;
    logic [PTR-1:0] w_wr_ptr;
    logic [PTR-1:0] w_rd_ptr;

    // Acceptance uses the registered flags, so a pop at full never frees room for a same-cycle push.
    assign w_push    = i_push_req & ~r_full;
    assign w_pop     = i_pop_req & ~r_empty;
    assign w_err_now = (i_push_req & r_full) | (i_pop_req & r_empty);

    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_count + CW'(1);
            2'b01:   w_cnt_nxt = r_count - CW'(1);
            default: w_cnt_nxt = r_count;
        endcase
    end

    fifo_ptr #(.PTR(PTR)) u_wr_ptr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_push),
        .o_ptr   (w_wr_ptr)
    );

    fifo_ptr #(.PTR(PTR)) u_rd_ptr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_pop),
        .o_ptr   (w_rd_ptr)
    );

    // Flags follow the next-state count so they change on the same edge as r_count.
    always_ff @(posedge i_clk) begin
        if (i_reset == RESET_ACTIVE) begin
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_data_valid   <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_count        <= w_cnt_nxt;
            r_full         <= (w_cnt_nxt == CW'(MEM_SIZE));
            r_empty        <= (w_cnt_nxt == '0);
            r_almost_full  <= (w_cnt_nxt >= i_thr_high);
            r_almost_empty <= (w_cnt_nxt <= i_thr_low);
            r_data_valid   <= w_pop;
`ifdef FIFO_ERR_STICKY_EN
            r_error        <= r_error | w_err_now;
`else
            r_error        <= w_err_now;
`endif
        end
    end

    assign o_push         = w_push;
    assign o_pop          = w_pop;
    assign o_wr_ptr       = w_wr_ptr;
    assign o_rd_ptr       = w_rd_ptr;
    assign o_fifo_count   = r_count;
    assign o_full         = r_full;
    assign o_empty        = r_empty;
    assign o_almost_full  = r_almost_full;
    assign o_almost_empty = r_almost_empty;
    assign o_data_valid   = r_data_valid;
    assign o_error        = r_error;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: a reference model queues the expected registered state per edge.
// Outputs are sampled 1 time unit after the edge; inputs are driven on the falling edge.
module tb_fifo_ctrl;
    logic       clk;
    logic       reset;
    logic       push_req;
    logic       pop_req;
    logic [3:0] thr_high;
    logic [3:0] thr_low;
    logic       push;
    logic       pop;
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] fifo_count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       data_valid;
    logic       error;

    typedef struct {
        logic [2:0] wr;
        logic [2:0] rd;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       dv;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [2:0] m_wr;
    logic [2:0] m_rd;
    logic [3:0] m_cnt;
    logic       m_err;

    fifo_ctrl dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_push_req     (push_req),
        .i_pop_req      (pop_req),
        .i_thr_high     (thr_high),
        .i_thr_low      (thr_low),
        .o_push         (push),
        .o_pop          (pop),
        .o_wr_ptr       (wr_ptr),
        .o_rd_ptr       (rd_ptr),
        .o_fifo_count   (fifo_count),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (almost_full),
        .o_almost_empty (almost_empty),
        .o_data_valid   (data_valid),
        .o_error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = exp_q.pop_front();
        chk("wr_ptr",       {5'b0, wr_ptr},     {5'b0, e.wr});
        chk("rd_ptr",       {5'b0, rd_ptr},     {5'b0, e.rd});
        chk("fifo_count",   {4'b0, fifo_count}, {4'b0, e.cnt});
        chk("full",         {7'b0, full},       {7'b0, e.full});
        chk("empty",        {7'b0, empty},      {7'b0, e.empty});
        chk("almost_full",  {7'b0, almost_full},  {7'b0, e.af});
        chk("almost_empty", {7'b0, almost_empty}, {7'b0, e.ae});
        chk("data_valid",   {7'b0, data_valid}, {7'b0, e.dv});
        chk("error",        {7'b0, error},      {7'b0, e.err});
    endtask

    task automatic do_reset(input logic pu, input logic po);
        exp_t e;
        @(negedge clk);
        reset = 1'b0; push_req = pu; pop_req = po;
        m_wr = 3'd0; m_rd = 3'd0; m_cnt = 4'd0; m_err = 1'b0;
        e = '{wr: 3'd0, rd: 3'd0, cnt: 4'd0, full: 1'b0, empty: 1'b1,
              af: 1'b0, ae: 1'b1, dv: 1'b0, err: 1'b0};
        exp_q.push_back(e);
        @(posedge clk); #1;
        compare_front();
        @(negedge clk);
        reset = 1'b1; push_req = 1'b0; pop_req = 1'b0;
    endtask

    task automatic step(input logic pu, input logic po, input logic [3:0] th, input logic [3:0] tl);
        exp_t e;
        logic m_full, m_empty, e_push, e_pop, e_err;
        @(negedge clk);
        push_req = pu; pop_req = po; thr_high = th; thr_low = tl;
        m_full  = (m_cnt == 4'd8);
        m_empty = (m_cnt == 4'd0);
        e_push  = pu & ~m_full;
        e_pop   = po & ~m_empty;
        e_err   = (pu & m_full) | (po & m_empty);
        #1;
        chk("push_strobe", {7'b0, push}, {7'b0, e_push});
        chk("pop_strobe",  {7'b0, pop},  {7'b0, e_pop});
        if (e_push) m_wr = m_wr + 3'd1;
        if (e_pop)  m_rd = m_rd + 3'd1;
        if (e_push && !e_pop) m_cnt = m_cnt + 4'd1;
        if (e_pop && !e_push) m_cnt = m_cnt - 4'd1;
`ifdef FIFO_ERR_STICKY_EN
        m_err = m_err | e_err;
`else
        m_err = e_err;
`endif
        e = '{wr: m_wr, rd: m_rd, cnt: m_cnt, full: (m_cnt == 4'd8), empty: (m_cnt == 4'd0),
              af: (m_cnt >= th), ae: (m_cnt <= tl), dv: e_pop, err: m_err};
        exp_q.push_back(e);
        @(posedge clk); #1;
        compare_front();
    endtask

    initial begin
        reset = 1'b0; push_req = 1'b0; pop_req = 1'b0;
        thr_high = 4'd6; thr_low = 4'd2;
        m_wr = 3'd0; m_rd = 3'd0; m_cnt = 4'd0; m_err = 1'b0;

        // Reset with a pending push must still clear everything
        do_reset(1'b1, 1'b0);

        // Fill to full; wr_ptr wraps to 0
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'd6, 4'd2);
        chk("fill_wr_wrap", {5'b0, wr_ptr}, 8'd0);
        chk("fill_full",    {7'b0, full},   8'd1);

        // Push at full: rejected, two one-cycle error pulses
        step(1'b1, 1'b0, 4'd6, 4'd2);
        step(1'b1, 1'b0, 4'd6, 4'd2);
        // Push and pop at full: pop accepted, push rejected
        step(1'b1, 1'b1, 4'd6, 4'd2);
        step(1'b1, 1'b0, 4'd6, 4'd2);

        // Drain to empty; rd_ptr wraps 7->0 (one extra pop already done)
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'd6, 4'd2);
        chk("drain_empty",   {7'b0, empty},  8'd1);
        step(1'b0, 1'b0, 4'd6, 4'd2);
        chk("dv_drops",      {7'b0, data_valid}, 8'd0);

        // Count 3 then simultaneous push/pop for 4 cycles
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd6, 4'd2);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'd6, 4'd2);
        chk("both_count", {4'b0, fifo_count}, 8'd3);

        // Thresholds above depth: almost_full never, almost_empty held
        step(1'b1, 1'b0, 4'd15, 4'd12);
        step(1'b0, 1'b0, 4'd15, 4'd12);

        // Back to empty, then push+pop together at empty
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'd6, 4'd2);
        step(1'b1, 1'b1, 4'd6, 4'd2);
        step(1'b0, 1'b0, 4'd6, 4'd2);
        step(1'b0, 1'b0, 4'd6, 4'd2);

        // Build to count 5, then reset mid-stream
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'd6, 4'd2);
        chk("pre_reset_count", {4'b0, fifo_count}, 8'd5);
        do_reset(1'b1, 1'b1);

        // First push after reset writes address 0
        @(negedge clk);
        push_req = 1'b1; #1;
        chk("post_reset_addr", {5'b0, wr_ptr}, 8'd0);
        push_req = 1'b0;
        step(1'b1, 1'b0, 4'd6, 4'd2);
        step(1'b0, 1'b1, 4'd6, 4'd2);
        step(1'b0, 1'b0, 4'd6, 4'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
